// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared types and sizing helpers for the button conditioner
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } deb_state_t;

  localparam int SYNC_STAGES = 2;

  // One spare bit so the terminal count n-1 always fits without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one channel: 2-flop synchronizer, debounce FSM, level and edge pulses
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic idle_hi_o
);

  localparam int               CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_t             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The sample that leaves an IDLE state already counts as the first stable cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CW'(1);
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CW'(1);
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign idle_hi_o = (state_q == IDLE_HI);

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced buttons and switch; BUTTON_CONDITIONER_AUTOREPEAT_EN adds press auto-repeat
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic [NUM_BTN-1:0] keys_raw,
  input  logic               chave_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               chave_level
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("button_conditioner: illegal debounce/repeat configuration");
  end

  logic [NUM_BTN-1:0] keys_norm;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] btn_idle_hi;
  logic               chave_rise_unused;
  logic               chave_fall_unused;
  logic               chave_idle_hi_unused;

  assign keys_norm = (BTN_ACTIVE_LOW != 0) ? ~keys_raw : keys_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk_i    (clk_clk),
      .rst_ni   (reset_reset_n),
      .raw_i    (keys_norm[i]),
      .level_o  (btn_level[i]),
      .rise_o   (btn_rise[i]),
      .fall_o   (btn_release[i]),
      .idle_hi_o(btn_idle_hi[i])
    );
  end

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_chave (
    .clk_i    (clk_clk),
    .rst_ni   (reset_reset_n),
    .raw_i    (chave_raw),
    .level_o  (chave_level),
    .rise_o   (chave_rise_unused),
    .fall_o   (chave_fall_unused),
    .idle_hi_o(chave_idle_hi_unused)
  );

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam int            HW        = cnt_width(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [HW-1:0]      hold_q [NUM_BTN];
  logic [HW-1:0]      hold_d [NUM_BTN];
  logic [NUM_BTN-1:0] rep_q, rep_d;

  // Reloading to DELAY-PERIOD makes every later repeat land PERIOD cycles apart.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      hold_d[i] = '0;
      rep_d[i]  = 1'b0;
      if (btn_idle_hi[i]) begin
        if (hold_q[i] == HOLD_LAST) begin
          rep_d[i]  = 1'b1;
          hold_d[i] = HOLD_RELOAD;
        end else begin
          hold_d[i] = hold_q[i] + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= '0;
      rep_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= hold_d[i];
      rep_q <= rep_d;
    end
  end

  assign btn_press = btn_rise | rep_q;
`else
  logic unused_idle_hi;
  assign unused_idle_hi = ^btn_idle_hi;
  assign btn_press      = btn_rise;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed bench for button_conditioner against a behavioural model
module tb_button_conditioner;

  localparam int D  = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] keys_raw = 3'b111;
  logic       chave_raw = 1'b0;
  logic [2:0] btn_level, btn_press, btn_release;
  logic       chave_level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN(3), .BTN_ACTIVE_LOW(1), .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .keys_raw     (keys_raw),
    .chave_raw    (chave_raw),
    .btn_level    (btn_level),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .chave_level  (chave_level)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Model: the FSM at edge e sees the raw value sampled at edge e-2; the level
  // flips once the last D such samples all disagree with it.
  logic [D+1:0] hist [4];
  logic [3:0]   lvl_m, pr_m, rl_m;
  int           run_m [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) hist[c] = '0;
      for (int c = 0; c < 3; c++) run_m[c] = 0;
      lvl_m = '0; pr_m = '0; rl_m = '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        logic raw;
        int   n;
        raw = (c < 3) ? ~keys_raw[c] : chave_raw;
        hist[c] = {hist[c][D:0], raw};
        pr_m[c] = 1'b0;
        rl_m[c] = 1'b0;
        if (hist[c][D+1:2] == {D{~lvl_m[c]}}) begin
          lvl_m[c] = ~lvl_m[c];
          if (lvl_m[c]) pr_m[c] = 1'b1;
          else          rl_m[c] = 1'b1;
        end
        if (c < 3) begin
          n = run_m[c];
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
          if (n == RD || (n > RD && ((n - RD) % RP) == 0)) pr_m[c] = 1'b1;
`endif
          run_m[c] = (lvl_m[c] && hist[c][2]) ? n + 1 : 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("outputs", 16'({btn_level, btn_press, btn_release, chave_level}),
          16'({lvl_m[2:0], pr_m[2:0], rl_m[2:0], lvl_m[3]}));
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    logic exp_rep;
    tick(1);
    for (int i = 0; i < 12; i++) begin
      keys_raw  = 3'($urandom);
      chave_raw = 1'($urandom);
      tick(1);
      check("reset_hold", 16'({btn_level, btn_press, btn_release, chave_level}), 16'h0);
    end
    keys_raw = 3'b111; chave_raw = 1'b0; rst_n = 1'b1;
    tick(20);
    check("post_reset_idle", 16'({btn_level, btn_press, btn_release, chave_level}), 16'h0);

    keys_raw[0] = 1'b0;
    tick(9);
    check("press_before_latency", 16'({btn_level, btn_press}), 16'h0);
    tick(1);
    check("press_level", 16'(btn_level), 16'h1);
    check("press_pulse", 16'(btn_press), 16'h1);
    tick(1);
    check("press_one_cycle", 16'(btn_press), 16'h0);
    keys_raw[0] = 1'b1;
    tick(9);
    check("release_before_latency", 16'({btn_level, btn_release}), 16'h8);
    tick(1);
    check("release_pulse", 16'({btn_level, btn_release}), 16'h1);
    tick(10);

    keys_raw[1] = 1'b0;
    tick(7);
    keys_raw[1] = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (btn_press[1]) seen++;
    end
    check("glitch_no_press", 16'(seen), 16'h0);
    check("glitch_level", 16'(btn_level), 16'h0);
    keys_raw[1] = 1'b0;
    tick(9);
    check("long_low_before_latency", 16'(btn_level), 16'h0);
    tick(1);
    check("long_low_accepted", 16'({btn_level, btn_press}), 16'h12);
    keys_raw[1] = 1'b1;
    tick(25);

    keys_raw = 3'b010;
    tick(10);
    check("simul_press", 16'({btn_level, btn_press}), 16'h2d);
    tick(1);
    check("simul_press_end", 16'(btn_press), 16'h0);
    keys_raw = 3'b111;
    tick(10);
    check("simul_release", 16'({btn_level, btn_release}), 16'h5);
    tick(1);
    check("simul_release_end", 16'(btn_release), 16'h0);
    tick(5);

    chave_raw = 1'b1; keys_raw[1] = 1'b0;
    tick(7);
    rst_n = 1'b0; keys_raw[1] = 1'b1;
    tick(3);
    check("mid_wait_reset", 16'({btn_level, btn_press, btn_release, chave_level}), 16'h0);
    rst_n = 1'b1;
    tick(9);
    check("chave_before_latency", 16'(chave_level), 16'h0);
    tick(1);
    check("chave_after_reset", 16'({btn_level, btn_press, chave_level}), 16'h1);
    chave_raw = 1'b0;
    tick(12);

    keys_raw[0] = 1'b0;
    tick(10);
    check("hold_accept", 16'(btn_press), 16'h1);
    for (int k = 1; k <= 35; k++) begin
      tick(1);
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
      exp_rep = (k == 20 || k == 25 || k == 30 || k == 35);
`else
      exp_rep = 1'b0;
`endif
      check($sformatf("repeat_%0d", k), 16'(btn_press[0]), 16'(exp_rep));
    end
    keys_raw[0] = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (btn_press[0]) seen++;
    end
    check("repeat_stopped", 16'(seen), 16'h0);
    check("hold_released", 16'(btn_level), 16'h0);

    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 3; c++)
        if ($urandom_range(0, 9) == 0) keys_raw[c] = ~keys_raw[c];
      if ($urandom_range(0, 9) == 0) chave_raw = ~chave_raw;
      rst_n = ($urandom_range(0, 1499) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the board push-buttons and slide switch before they reach the display controller's conduit (buttons[2:0], chave).
- Per channel: 2-flop synchronizer, counter-based debounce FSM, one-cycle press/release pulses.
- Outputs are clean, active-high and clk_clk-synchronous; btn_press drives the display controller's buttons input and chave_level drives chave.

Parameters:
- NUM_BTN, 3, number of push-button channels.
- BTN_ACTIVE_LOW, 1, 1: raw key reads 0 when pressed (board KEYs); 0: raw key reads 1 when pressed.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a change (10 ms at 50 MHz); legal range >= 2.
- REPEAT_DELAY, 25000000, auto-repeat hold time before the first repeat (feature only).
- REPEAT_PERIOD, 10000000, auto-repeat interval (feature only).

Ports:
- clk_clk  input  1  system clock, 50 MHz.
- reset_reset_n  input  1  asynchronous active-low reset.
- keys_raw  input  NUM_BTN  asynchronous push-button pins.
- chave_raw  input  1  asynchronous slide switch, active-high.
- btn_level  output  NUM_BTN  debounced state, 1 = pressed.
- btn_press  output  NUM_BTN  one-cycle pulse on accepted press (plus repeats when enabled).
- btn_release  output  NUM_BTN  one-cycle pulse on accepted release.
- chave_level  output  1  debounced switch state.

Behaviour:
- Reset (async assert, sync release):
  - Sync flops load the released/0 value.
  - All FSMs go to IDLE_LO; counters clear.
  - btn_level, btn_press, btn_release and chave_level are 0.
- Polarity: keys are normalised to active-high at the synchronizer input (inverted when BTN_ACTIVE_LOW=1); s denotes the 2nd sync flop output.
- Channel FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
  - IDLE_LO: s=1 -> WAIT_HI, cnt=1.
  - WAIT_HI, s=1 and cnt<DEBOUNCE_CYCLES-1: cnt++.
  - WAIT_HI, s=1 and cnt==DEBOUNCE_CYCLES-1: -> IDLE_HI; level<=1; press<=1 for one cycle.
  - WAIT_HI, s=0: -> IDLE_LO, cnt=0; no output change (glitch rejected).
  - IDLE_HI, WAIT_LO: mirror image; the release pulse accompanies level<=0.
- Latency: raw edge to level/pulse edge = 2 sync cycles + DEBOUNCE_CYCLES cycles, with the raw input held throughout.
- Pulses:
  - Registered and high for exactly one cycle, in the first cycle level shows the new value.
  - press and release on one channel never coincide.
- Counter width is $clog2(DEBOUNCE_CYCLES)+1; cnt never exceeds DEBOUNCE_CYCLES-1 (no wrap).
- Channels are fully independent; simultaneous presses on several channels give same-cycle pulses on each.
- chave uses the same FSM; its pulses are left unconnected.
- Input held through reset: after release the FSM starts at IDLE_LO and the press is accepted normally after full latency (one press pulse).
- Reset asserted mid-WAIT: the count is discarded and no pulse is emitted.

Optional Feature:
- Macro: BUTTON_CONDITIONER_AUTOREPEAT_EN.
- Defined:
  - Per-button hold counter runs while in IDLE_HI.
  - After REPEAT_DELAY cycles in IDLE_HI, emit an extra btn_press pulse, then one every REPEAT_PERIOD cycles until leaving IDLE_HI.
  - Leaving IDLE_HI clears the hold counter.
  - btn_release and btn_level are unaffected; chave is never auto-repeated.
- Undefined: no hold counters; exactly one btn_press per accepted press.

Decomposition:
- Package button_conditioner_pkg:
  - Typedef deb_state_t (IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO).
  - Constant SYNC_STAGES=2.
  - Function cnt_width(n).
- Sub-module debounce_channel:
  - Contains sync + FSM + counter, with DEBOUNCE_CYCLES parameter.
  - Outputs level, rise pulse, fall pulse.
  - Instantiated NUM_BTN+1 times.
- Auto-repeat logic lives in the top, per button, under the macro.

Test Plan:
- Sim uses DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Reset value: hold reset_reset_n=0, toggle keys randomly -> all outputs 0; release reset with keys_raw=3'b111 -> outputs stay 0.
- Clean press: keys_raw[0] 1->0 and held -> btn_level[0]=1 and btn_press[0]=1 exactly 10 cycles after the edge; press high 1 cycle; other bits 0.
- Glitch rejection: keys_raw[1] low for 7 cycles then high -> no press pulse, level stays 0; a later 8+-cycle low is accepted with full latency.
- Release and simultaneous channels:
  - Keys 0 and 2 pressed on the same cycle -> same-cycle press pulses.
  - Both released -> btn_release pulses 10 cycles after the release edge; level 0.
- Reset mid-operation: assert reset 5 cycles into WAIT_HI -> no pulse; chave_raw=1 held through reset -> chave_level=1 at 10 cycles after deassert.
- Auto-repeat (macro on): hold key 0 -> press pulses at acceptance, +20, +25, +30 cycles; release stops repeats; macro off -> single pulse.
